muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Iterative sequencer for the RV32M multiply/divide instructions in the execute stage.
- Takes operands from the EX operand muxes and runs a shift-add multiplier or a restoring divider, one bit per cycle.
- Holds the pipeline with a stall while it runs, then presents the result for one cycle to the EX result mux.
- Base-ALU instructions never enter this block.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- req_valid  input  1  EX holds an M-extension op (opcode 0110011, funct7 0000001)
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op1  input  XLEN  rs1 value
- op2  input  XLEN  rs2 value
- flush  input  1  kill the in-flight op (branch/jump redirect)
- stall  output  1  freeze PC, IF/ID and ID/EX registers
- done  output  1  result valid this cycle (one-cycle pulse)
- result  output  XLEN  final result; holds until next accept

Behaviour:
- Reset (sync, dominates all inputs): state=IDLE, done=0, result=0, counter=0, accumulators=0. Reset mid-operation aborts with no done.
- States: IDLE, MUL, DIV, DONE.
- IDLE: on req_valid & ~flush, latch funct3 and the operand signs. Latch magnitudes: abs(op) for signed operands; op1 only for MULHSU. Load counter=XLEN-1.
  - funct3[2]=0 goes to MUL.
  - funct3[2]=1 with op2==0 goes to DONE. Quotient = all ones; remainder = op1 unchanged.
  - funct3[2]=1, signed (DIV/REM), op1==0x80000000 and op2==0xFFFFFFFF goes to DONE. Quotient = 0x80000000; remainder = 0.
  - Any other divide goes to DIV.
- MUL: one cycle per bit. If the multiplier LSB is set, add the multiplicand into the 2*XLEN product. Shift multiplier right and multiplicand left. Counter decrements. At counter==0 go to DONE.
- DIV: restoring. Shift {rem,quot} left 1. If rem>=divisor, subtract and set the quotient LSB. At counter==0 go to DONE.
- DONE:
  - Apply sign fix: negate the product if the operand signs differ. Quotient is negated if the signs differ. Remainder takes the dividend's sign.
  - Select the output: MUL takes the low word; MULH/MULHSU/MULHU take the high word; DIV/DIVU the quotient; REM/REMU the remainder.
  - Register it into result, pulse done=1, return to IDLE.
  - Special cases take the same DONE path with no sign fix.
- Latency: request accepted in cycle 0. Iterative ops: done in cycle XLEN+1 (33). Special divides: done in cycle 1.
- stall = (IDLE & req_valid & ~flush) | MUL | DIV. stall is combinational and 0 in DONE, so the pipeline advances with the result.
- In DONE, req_valid of the still-present instruction is ignored. A new request is accepted only from IDLE, the cycle after DONE.
- flush in MUL/DIV/DONE: next state IDLE, done stays 0, result unchanged. flush beats a same-cycle accept in IDLE.
- Width: the product accumulator is 2*XLEN. The remainder path is XLEN+1 bits for the compare/subtract. The counter is clog2(XLEN) bits.
- Out-of-range funct3 cannot occur (3-bit field fully decoded).

Test Plan:
- MUL op1=7, op2=0xFFFFFFFD (-3) -> stall high cycles 0-32; done=1 in cycle 33; result=0xFFFFFFEB. Repeat with MULHU op1=op2=0xFFFFFFFF -> result=0xFFFFFFFE.
- DIV op1=0xFFFFFFF9 (-7), op2=2 -> result=0xFFFFFFFD in cycle 33. REM with the same operands -> 0xFFFFFFFF. DIVU with the same operands -> 0x7FFFFFFC.
- Divide by zero: DIVU op1=5, op2=0 -> done in cycle 1, result=0xFFFFFFFF. REMU with the same operands -> result=5 in cycle 1; stall high only in cycle 0.
- Overflow: DIV op1=0x80000000, op2=0xFFFFFFFF -> done cycle 1, result=0x80000000. REM with the same operands -> result=0. DIVU with the same operands -> iterative, result=0 in cycle 33.
- flush asserted in cycle 10 of a DIV -> stall low from cycle 11, no done pulse, result keeps its prior value. A new MUL req in cycle 11 is accepted and completes normally in cycle 44.
- rst asserted in cycle 5 of a MUL -> cycle 6: stall=0, done=0, result=0. Back-to-back MULH 0x80000000*0x80000000 then MULHSU 0xFFFFFFFF*0xFFFFFFFF -> results 0x40000000 then 0xFFFFFFFF, each 34 cycles apart.

Source files
------------

// File: rtl/muldiv_seq_if.sv
// rtl/muldiv_seq_if.sv - EX-stage request/result bundle for the M-extension sequencer
interface muldiv_seq_if #(parameter int XLEN = 32);
   logic            req_valid;
   logic [2:0]      funct3;
   logic [XLEN-1:0] op1;
   logic [XLEN-1:0] op2;
   logic            flush;
   logic            stall;
   logic            done;
   logic [XLEN-1:0] result;

   modport master (
      output req_valid, funct3, op1, op2, flush,
      input  stall, done, result
   );

   modport slave (
      input  req_valid, funct3, op1, op2, flush,
      output stall, done, result
   );
endinterface

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative RV32M multiply/divide sequencer, one bit per cycle
module muldiv_seq #(
   parameter int XLEN = 32
) (
   input  logic        clk,
   input  logic        rst,
   muldiv_seq_if.slave bus
);
   localparam int CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t            state_q;
   logic [2:0]        funct3_q;
   logic              neg1_q;
   logic              neg2_q;
   logic              special_q;
   logic [CW-1:0]     cnt_q;
   logic [2*XLEN-1:0] mcand_q;
   logic [2*XLEN-1:0] prod_q;
   logic [XLEN-1:0]   mplier_q;
   logic [XLEN-1:0]   quot_q;
   logic [XLEN-1:0]   rem_q;
   logic [XLEN-1:0]   divisor_q;
   logic [XLEN-1:0]   result_q;

   logic              accept;
   logic              sgn1;
   logic              sgn2;
   logic              neg1_in;
   logic              neg2_in;
   logic [XLEN-1:0]   mag1;
   logic [XLEN-1:0]   mag2;
   logic              div_zero;
   logic              div_ovf;

   logic [2*XLEN-1:0] prod_d;
   logic [2*XLEN-1:0] mcand_d;
   logic [XLEN-1:0]   mplier_d;
   logic [XLEN:0]     rem_sh;
   logic [XLEN:0]     rem_diff;
   logic [XLEN-1:0]   rem_d;
   logic [XLEN-1:0]   quot_d;

   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quot_fix;
   logic [XLEN-1:0]   rem_fix;
   logic [XLEN-1:0]   res_fix;
   logic              done_now;

   assign accept = (state_q == S_IDLE) & bus.req_valid & ~bus.flush;

   // MULHSU treats only rs1 as signed; MULHU/DIVU/REMU treat neither.
   always_comb begin
      sgn1 = 1'b0;
      sgn2 = 1'b0;
      case (bus.funct3)
         3'b000, 3'b001, 3'b100, 3'b110: begin
            sgn1 = 1'b1;
            sgn2 = 1'b1;
         end
         3'b010:  sgn1 = 1'b1;
         default: ;
      endcase
   end

   assign neg1_in  = sgn1 & bus.op1[XLEN-1];
   assign neg2_in  = sgn2 & bus.op2[XLEN-1];
   assign mag1     = neg1_in ? -bus.op1 : bus.op1;
   assign mag2     = neg2_in ? -bus.op2 : bus.op2;
   assign div_zero = (bus.op2 == '0);
   assign div_ovf  = sgn2 & (bus.op1 == INT_MIN) & (bus.op2 == '1);

   assign prod_d   = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
   assign mcand_d  = mcand_q << 1;
   assign mplier_d = mplier_q >> 1;

   // A borrow out of the XLEN+1 bit subtract means the partial remainder is below the divisor.
   assign rem_sh   = {rem_q, quot_q[XLEN-1]};
   assign rem_diff = rem_sh - {1'b0, divisor_q};
   assign rem_d    = rem_diff[XLEN] ? rem_sh[XLEN-1:0] : rem_diff[XLEN-1:0];
   assign quot_d   = {quot_q[XLEN-2:0], ~rem_diff[XLEN]};

   always_comb begin
      prod_fix = prod_q;
      quot_fix = quot_q;
      rem_fix  = rem_q;
      if (!special_q) begin
         if (neg1_q ^ neg2_q) begin
            prod_fix = -prod_q;
            quot_fix = -quot_q;
         end
         if (neg1_q) begin
            rem_fix = -rem_q;
         end
      end
      res_fix = '0;
      case (funct3_q)
         3'b000:                 res_fix = prod_fix[XLEN-1:0];
         3'b001, 3'b010, 3'b011: res_fix = prod_fix[2*XLEN-1:XLEN];
         3'b100, 3'b101:         res_fix = quot_fix;
         default:                res_fix = rem_fix;
      endcase
   end

   assign done_now   = (state_q == S_DONE) & ~bus.flush;
   assign bus.done   = done_now;
   assign bus.result = done_now ? res_fix : result_q;
   assign bus.stall  = accept | (state_q == S_MUL) | (state_q == S_DIV);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         funct3_q  <= '0;
         neg1_q    <= 1'b0;
         neg2_q    <= 1'b0;
         special_q <= 1'b0;
         cnt_q     <= '0;
         mcand_q   <= '0;
         prod_q    <= '0;
         mplier_q  <= '0;
         quot_q    <= '0;
         rem_q     <= '0;
         divisor_q <= '0;
         result_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  funct3_q  <= bus.funct3;
                  neg1_q    <= neg1_in;
                  neg2_q    <= neg2_in;
                  special_q <= 1'b0;
                  cnt_q     <= CW'(XLEN-1);
                  mcand_q   <= {{XLEN{1'b0}}, mag1};
                  mplier_q  <= mag2;
                  prod_q    <= '0;
                  quot_q    <= mag1;
                  rem_q     <= '0;
                  divisor_q <= mag2;
                  if (!bus.funct3[2]) begin
                     state_q <= S_MUL;
                  end else if (div_zero) begin
                     special_q <= 1'b1;
                     quot_q    <= '1;
                     rem_q     <= bus.op1;
                     state_q   <= S_DONE;
                  end else if (div_ovf) begin
                     special_q <= 1'b1;
                     quot_q    <= INT_MIN;
                     rem_q     <= '0;
                     state_q   <= S_DONE;
                  end else begin
                     state_q <= S_DIV;
                  end
               end
            end
            S_MUL: begin
               if (bus.flush) begin
                  state_q <= S_IDLE;
               end else begin
                  prod_q   <= prod_d;
                  mcand_q  <= mcand_d;
                  mplier_q <= mplier_d;
                  cnt_q    <= cnt_q - 1'b1;
                  if (cnt_q == '0) begin
                     state_q <= S_DONE;
                  end
               end
            end
            S_DIV: begin
               if (bus.flush) begin
                  state_q <= S_IDLE;
               end else begin
                  rem_q  <= rem_d;
                  quot_q <= quot_d;
                  cnt_q  <= cnt_q - 1'b1;
                  if (cnt_q == '0) begin
                     state_q <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               if (!bus.flush) begin
                  result_q <= res_fix;
               end
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - self-checking bench for muldiv_seq
module tb_muldiv_seq;
   localparam int XLEN = 32;
   localparam logic [31:0] MIN = 32'h8000_0000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   muldiv_seq_if #(.XLEN(XLEN)) bus ();
   muldiv_seq #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

   int checks = 0;
   int errors = 0;
   logic [31:0] last_res = '0;

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
      string       name;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%08h expected=%08h", nm, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      longint sa;
      longint sb;
      longint ua;
      longint ub;
      longint p;
      int     si;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      case (f3)
         3'b000: begin p = sa * sb; return p[31:0]; end
         3'b001: begin p = sa * sb; return p[63:32]; end
         3'b010: begin p = sa * ub; return p[63:32]; end
         3'b011: begin p = ua * ub; return p[63:32]; end
         3'b100: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == MIN && b == 32'hFFFF_FFFF) return MIN;
            si = $signed(a) / $signed(b);
            return si;
         end
         3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'b110: begin
            if (b == 0) return a;
            if (a == MIN && b == 32'hFFFF_FFFF) return 32'd0;
            si = $signed(a) % $signed(b);
            return si;
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int model_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      if (f3[2] && (b == 0 || (!f3[0] && a == MIN && b == 32'hFFFF_FFFF))) return 1;
      return XLEN + 1;
   endfunction

   function automatic logic [31:0] pick();
      logic [31:0] v;
      case ($urandom_range(0, 5))
         0:       v = 32'd0;
         1:       v = 32'hFFFF_FFFF;
         2:       v = MIN;
         3:       v = $urandom_range(0, 15);
         default: v = $urandom;
      endcase
      return v;
   endfunction

   // Presents one op in the next cycle (cycle 0) and holds it until done.
   task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input string nm);
      int          got_lat;
      logic [31:0] got_res;
      bit          stall_bad;
      got_lat   = -1;
      got_res   = '0;
      stall_bad = 1'b0;
      step();
      bus.req_valid = 1'b1;
      bus.flush     = 1'b0;
      bus.funct3    = f3;
      bus.op1       = a;
      bus.op2       = b;
      for (int c = 0; c < 40; c++) begin
         if (c != 0) step();
         @(negedge clk);
         if (c == 0) chk({nm, " hold"}, bus.result, last_res);
         if (bus.done) begin
            got_lat = c;
            got_res = bus.result;
            chk({nm, " stall@done"}, 32'(bus.stall), 32'd0);
            break;
         end
         if (!bus.stall) stall_bad = 1'b1;
      end
      chk({nm, " latency"}, 32'(got_lat), 32'(lat));
      chk({nm, " result"}, got_res, exp);
      chk({nm, " stall"}, 32'(stall_bad), 32'd0);
      last_res = exp;
   endtask

   task automatic idle(input int n, input string nm);
      bit bad;
      bad = 1'b0;
      for (int i = 0; i < n; i++) begin
         step();
         bus.req_valid = 1'b0;
         bus.flush     = 1'b0;
         @(negedge clk);
         if (bus.done || bus.stall) bad = 1'b1;
      end
      chk({nm, " quiet"}, 32'(bad), 32'd0);
   endtask

   initial begin
      bit          bad;
      logic [2:0]  rf;
      logic [31:0] ra;
      logic [31:0] rb;

      vecs.push_back('{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul"});
      vecs.push_back('{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu"});
      vecs.push_back('{3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, "div"});
      vecs.push_back('{3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, "rem"});
      vecs.push_back('{3'b101, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, 33, "divu"});
      vecs.push_back('{3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF, 1,  "divu0"});
      vecs.push_back('{3'b111, 32'd5,          32'd0,         32'd5,         1,  "remu0"});
      vecs.push_back('{3'b100, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 1,  "div0"});
      vecs.push_back('{3'b110, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1,  "rem0"});
      vecs.push_back('{3'b100, MIN,            32'hFFFF_FFFF, MIN,           1,  "div ovf"});
      vecs.push_back('{3'b110, MIN,            32'hFFFF_FFFF, 32'd0,         1,  "rem ovf"});
      vecs.push_back('{3'b101, MIN,            32'hFFFF_FFFF, 32'd0,         33, "divu big"});
      vecs.push_back('{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "mulhsu"});

      rst = 1'b1;
      bus.req_valid = 1'b0;
      bus.flush     = 1'b0;
      bus.funct3    = '0;
      bus.op1       = '0;
      bus.op2       = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset stall", 32'(bus.stall), 32'd0);
      chk("reset done", 32'(bus.done), 32'd0);
      chk("reset result", bus.result, 32'd0);
      step();
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < vecs.size(); i++) begin
         do_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, vecs[i].name);
      end

      for (int i = 0; i < 40; i++) begin
         rf = 3'($urandom_range(0, 7));
         ra = pick();
         rb = pick();
         do_op(rf, ra, rb, model(rf, ra, rb), model_lat(rf, ra, rb), $sformatf("rand%0d f3=%0d", i, rf));
      end
      idle(2, "post rand");

      // Flush in cycle 10 of a DIV, new MUL accepted in cycle 11.
      bad = 1'b0;
      step();
      bus.req_valid = 1'b1;
      bus.funct3    = 3'b100;
      bus.op1       = 32'hFFFF_FFF9;
      bus.op2       = 32'd2;
      @(negedge clk);
      for (int c = 1; c <= 10; c++) begin
         step();
         if (c == 10) bus.flush = 1'b1;
         @(negedge clk);
         if (bus.done) bad = 1'b1;
      end
      chk("divflush nodone", 32'(bad), 32'd0);
      chk("divflush result", bus.result, last_res);
      do_op(3'b000, 32'd6, 32'd7, 32'd42, 33, "mul after flush");

      // Flush beats a same-cycle accept in IDLE.
      step();
      bus.req_valid = 1'b1;
      bus.flush     = 1'b1;
      bus.funct3    = 3'b000;
      bus.op1       = 32'd2;
      bus.op2       = 32'd3;
      @(negedge clk);
      chk("idle flush stall", 32'(bus.stall), 32'd0);
      idle(36, "idle flush");

      // Flush arriving in the DONE cycle suppresses done and keeps the old result.
      bad = 1'b0;
      step();
      bus.req_valid = 1'b1;
      bus.flush     = 1'b0;
      bus.funct3    = 3'b000;
      bus.op1       = 32'd3;
      bus.op2       = 32'd5;
      @(negedge clk);
      for (int c = 1; c <= 33; c++) begin
         step();
         if (c == 33) bus.flush = 1'b1;
         @(negedge clk);
         if (bus.done) bad = 1'b1;
      end
      chk("doneflush nodone", 32'(bad), 32'd0);
      step();
      bus.flush     = 1'b0;
      bus.req_valid = 1'b0;
      @(negedge clk);
      chk("doneflush result", bus.result, last_res);

      // Reset in cycle 5 of a MUL.
      step();
      bus.req_valid = 1'b1;
      bus.funct3    = 3'b000;
      bus.op1       = 32'd9;
      bus.op2       = 32'd9;
      @(negedge clk);
      for (int c = 1; c <= 5; c++) begin
         step();
         if (c == 5) rst = 1'b1;
         @(negedge clk);
      end
      step();
      rst = 1'b0;
      bus.req_valid = 1'b0;
      @(negedge clk);
      chk("midrst stall", 32'(bus.stall), 32'd0);
      chk("midrst done", 32'(bus.done), 32'd0);
      chk("midrst result", bus.result, 32'd0);
      last_res = '0;
      idle(36, "midrst");

      // Back-to-back: second request accepted the cycle after DONE.
      do_op(3'b001, MIN, MIN, 32'h4000_0000, 33, "b2b mulh");
      do_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "b2b mulhsu");
      idle(2, "end");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
